// File: rtl/branch_unit.sv
// ----------------------------------------------------------------------------
// branch_unit
//   Jump/branch unit. It assembles a multi-byte target address from the data
//   bus, MSB byte first, and evaluates a condition code against flags captured
//   at start. It then issues a one-cycle PC load, either absolute or relative
//   to the captured PC. An optional circular return-address stack provides
//   call/return.
//
// Configuration macro:
//   BRANCH_RAS_EN  defined   -> return-address stack with call/return built
//                  undefined -> no stack; call acts as a jump, return never
//                               taken, ras_ovf/ras_unf tied low
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cins[7:0]         [3:0] cond select, [4] relative, [5] call, [6] return
//   i_start             begin a branch (IDLE only)
//   i_databus           address byte source
//   i_byte_valid        databus holds next address byte (COLLECT only)
//   i_pcin              current PC
//   i_zflag/oflag/cflag/sflag  ALU flags
//   o_busy              FSM not idle
//   o_done              one-cycle pulse in ISSUE
//   o_pcoe, o_pcout     PC load enable and target (target zero when not loading)
//   o_ras_ovf/o_ras_unf sticky stack overflow/underflow
// ----------------------------------------------------------------------------
module branch_unit #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_cins,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_databus,
    input  logic              i_byte_valid,
    input  logic [ADDR_W-1:0] i_pcin,
    input  logic              i_zflag,
    input  logic              i_oflag,
    input  logic              i_cflag,
    input  logic              i_sflag,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pcoe,
    output logic [ADDR_W-1:0] o_pcout,
    output logic              o_ras_ovf,
    output logic              o_ras_unf
);

    localparam int unsigned NBYTES = ADDR_W / DATA_W;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]        r_sel;
    logic              r_rel;
    logic              r_call;
    logic              r_ret;
    logic              r_z;
    logic              r_o;
    logic              r_c;
    logic              r_s;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_last_byte;
    logic [ADDR_W-1:0] w_addr_shift;
    logic              w_cond;
    logic              w_taken;
    logic [ADDR_W-1:0] w_ret_tgt;
    logic [ADDR_W-1:0] w_target;

    // Truncating the concatenation keeps the low ADDR_W bits, which is a
    // left shift by one byte that also works when NBYTES == 1.
    assign w_addr_shift = ADDR_W'({r_addr, i_databus});
    assign w_last_byte  = i_byte_valid && (r_cnt == CNT_W'(NBYTES - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_pcoe  = 1'b0;
        o_pcout = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = i_cins[6] ? S_ISSUE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                o_busy = 1'b1;
                if (w_last_byte) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_busy  = 1'b1;
                o_done  = 1'b1;
                o_pcoe  = w_taken;
                o_pcout = w_taken ? w_target : '0;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture registers and address assembly
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel  <= '0;
            r_rel  <= 1'b0;
            r_call <= 1'b0;
            r_ret  <= 1'b0;
            r_z    <= 1'b0;
            r_o    <= 1'b0;
            r_c    <= 1'b0;
            r_s    <= 1'b0;
            r_pc   <= '0;
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sel  <= i_cins[3:0];
                        r_rel  <= i_cins[4];
                        r_call <= i_cins[5];
                        r_ret  <= i_cins[6];
                        r_z    <= i_zflag;
                        r_o    <= i_oflag;
                        r_c    <= i_cflag;
                        r_s    <= i_sflag;
                        r_pc   <= i_pcin;
                        r_cnt  <= '0;
                    end
                end
                S_COLLECT: begin
                    if (i_byte_valid) begin
                        r_addr <= w_addr_shift;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation on captured flags
    // ------------------------------------------------------------------
    always_comb begin
        w_cond = 1'b0;
        case (r_sel)
            4'd0:    w_cond = 1'b1;
            4'd1:    w_cond = r_z;
            4'd2:    w_cond = !r_z;
            4'd3:    w_cond = r_c;
            4'd4:    w_cond = r_c | r_z;
            4'd5:    w_cond = !(r_c | r_z);
            4'd6:    w_cond = !r_c | r_z;
            4'd7:    w_cond = r_o ^ r_s;
            4'd8:    w_cond = (r_o ^ r_s) | r_z;
            4'd9:    w_cond = (r_o == r_s) & !r_z;
            4'd10:   w_cond = (r_o == r_s) | r_z;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_target = r_ret ? w_ret_tgt :
                      r_rel ? (r_pc + r_addr) : r_addr;

`ifdef BRANCH_RAS_EN
    // ------------------------------------------------------------------
    // Circular return-address stack: r_wp is the next free slot, r_depth
    // the number of valid entries (saturates at RAS_DEPTH on overflow).
    // ------------------------------------------------------------------
    localparam int unsigned PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned SCNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [SCNT_W-1:0] r_depth;
    logic              r_ovf;
    logic              r_unf;

    logic [PTR_W-1:0]  w_wp_inc;
    logic [PTR_W-1:0]  w_wp_dec;
    logic              w_cond_eff;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_unf_evt;
    logic              w_unused;

    assign w_wp_inc = (r_wp == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
    assign w_wp_dec = (r_wp == '0) ? PTR_W'(RAS_DEPTH - 1) : r_wp - PTR_W'(1);

    // call+return together disables both paths
    assign w_cond_eff = w_cond & !(r_call & r_ret);
    assign w_empty    = (r_depth == '0);
    assign w_taken    = r_ret ? (w_cond_eff & !w_empty) : w_cond_eff;
    assign w_ret_tgt  = r_ras[w_wp_dec];

    assign w_push    = o_done & !r_ret & r_call & w_cond_eff;
    assign w_pop     = o_done & r_ret & w_cond_eff & !w_empty;
    assign w_unf_evt = o_done & r_ret & w_cond_eff & w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_ras[r_wp] <= r_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= w_wp_inc;
                if (r_depth == SCNT_W'(RAS_DEPTH)) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_depth <= r_depth + SCNT_W'(1);
                end
            end else if (w_pop) begin
                r_wp    <= w_wp_dec;
                r_depth <= r_depth - SCNT_W'(1);
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign o_ras_ovf = r_ovf;
    assign o_ras_unf = r_unf;
    assign w_unused  = i_cins[7];
`else
    localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;

    logic w_unused;

    // Without a stack a return can never be taken and call is ignored.
    assign w_taken   = !r_ret & w_cond;
    assign w_ret_tgt = '0;
    assign o_ras_ovf = 1'b0;
    assign o_ras_unf = 1'b0;
    assign w_unused  = ^{i_cins[7], r_call};
`endif

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised jump/branch unit for the CPU datapath. It collects a multi-byte target address from the data bus and evaluates a condition code against the ALU flags. It then issues a one-cycle PC load, either absolute or PC-relative. A return-address stack supports call/return. It sits between the instruction decoder (`cins`, strobes), the data bus and the program counter (`pcin`, `pcoe`, `pcout`).

## Interface
- `ADDR_W`, 16: PC/address width; must be a multiple of `DATA_W`.
- `DATA_W`, 8: data bus width; `NBYTES = ADDR_W/DATA_W` (≥1).
- `RAS_DEPTH`, 4: return-address stack entries (≥1).

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `cins`  in  8  branch instruction. [3:0] condition select, [4] relative, [5] call, [6] return, [7] unused.
- `start`  in  1  latch `cins`, flags and `pcin`; begin a branch (IDLE only).
- `databus`  in  DATA_W  address byte source.
- `byte_valid`  in  1  `databus` holds the next address byte (COLLECT only).
- `pcin`  in  ADDR_W  current PC.
- `zflag`, `oflag`, `cflag`, `sflag`  in  1 each  ALU flags.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse in ISSUE, whether or not the branch is taken.
- `pcoe`  out  1  PC load enable; high only in ISSUE when taken.
- `pcout`  out  ADDR_W  target; 0 whenever `pcoe`=0.
- `ras_ovf`, `ras_unf`  out  1 each  sticky stack overflow/underflow; cleared only by `rst`.

## Operation
- Condition select:
  - 0 always.
  - 1 eq = Z.
  - 2 neq = !Z.
  - 3 ls = C.
  - 4 leq = C|Z.
  - 5 lg = !(C|Z).
  - 6 lge = !C|Z.
  - 7 sls = O^S.
  - 8 sleq = (O^S)|Z.
  - 9 slg = (O==S)&!Z.
  - 10 slge = (O==S)|Z.
  - 11–15 never.
- Flags, `cins` and `pcin` are captured on the accepted `start` edge. Later flag changes do not affect the branch.
- FSM states: IDLE, COLLECT, ISSUE.
  - IDLE: `start` with `cins[6]`=1 goes to ISSUE. Any other `start` goes to COLLECT with the byte counter cleared. `byte_valid` is ignored.
  - COLLECT: each `byte_valid` shifts `databus` into the address register, MSB byte first, and increments the counter. The edge accepting byte `NBYTES` goes to ISSUE. `start` is ignored.
  - ISSUE: lasts one cycle, then returns to IDLE. `start` and `byte_valid` are ignored.
- Target in ISSUE:
  - return: top of stack.
  - relative: captured `pcin` + assembled address, mod 2^ADDR_W, zero-extended (no sign extension).
  - otherwise: the assembled address.
- Taken = condition true. For return, the stack must also be non-empty.
- Call taken: push the captured `pcin`.
  - Stack full: the oldest entry is overwritten (circular), `ras_ovf` is set, and the jump still proceeds.
- Return with condition true:
  - Stack non-empty: pop and jump.
  - Stack empty: `pcoe`=0, `ras_unf` set, no pop.
- The condition is false for both call and return when `cins[5]` and `cins[6]` are both set: no push, no pop, return path, not taken.
- Reset (any state, including mid-collect):
  - state = IDLE, stack emptied, address register and counter = 0.
  - all outputs 0.

## Timing
- `start` accepted at edge T.
  - Jump/call: ISSUE during the cycle after the edge that accepts the last byte. Minimum latency is `NBYTES`+1 cycles from `start`.
  - Return: ISSUE during the cycle after T.
- `byte_valid` gaps are allowed; COLLECT waits indefinitely.
- `pcoe`, `pcout` and `done` are valid only during ISSUE. They are derived from registered state.
- Stack push/pop commits on the edge ending ISSUE. The next branch sees the updated stack.
- A back-to-back `start` is accepted in the cycle after ISSUE, when the FSM is back in IDLE.

## Configuration
- `BRANCH_RAS_EN` defined: the return stack and call/return semantics are present as described.
- Undefined: no stack storage is built.
  - `cins[5]` is ignored, so a call behaves as a plain jump.
  - `cins[6]`=1 still skips COLLECT but is never taken (`pcoe`=0, `done`=1).
  - `ras_ovf` and `ras_unf` are tied to 0.

## Test plan
All scenarios use defaults (ADDR_W=16, DATA_W=8, RAS_DEPTH=4).
- Absolute always: `cins`=0x00, bytes 0x12, 0x34 → ISSUE cycle with `pcoe`=1, `pcout`=0x1234, `done`=1. Latency 3 cycles.
- Relative neq with wrap: `pcin`=0xFFF0, Z=0, `cins`=0x12, bytes 0x00, 0x20 → `pcout`=0x0010. Repeat with Z=1 → `pcoe`=0, `pcout`=0, `done`=1.
- Signed condition: O=1, S=0, `cins`=0x07, bytes 0xAB, 0xCD → `pcout`=0xABCD. With O=S=1 → not taken. Flags toggled after `start` have no effect.
- Call/return: call from `pcin`=0x0100 to 0x2000, then return (`cins`=0x40) → `pcout`=0x0100 one cycle after `start`.
- Stack limits: 5 calls → `ras_ovf`=1; 4 returns yield the last 4 pushed `pcin` values in LIFO order; 5th return → `pcoe`=0, `ras_unf`=1.
- Reset mid-collect after one byte → IDLE, `busy`=0. A fresh branch then assembles correctly, with no stale byte.
